// File: rtl/usb_stream_pkg.sv
// Shared constants and types for the FX3 USB streaming path.
// One 128-bit word holds four {Q,I} lanes; one FX3 buffer holds 8192 bytes.
package usb_stream_pkg;
  localparam int LANES         = 4;
  localparam int LANE_W        = 32;
  localparam int WORD_W        = LANES * LANE_W;
  localparam int FX3_BUF_BYTES = 8192;
  localparam int LANE_CNT_W    = $clog2(LANES);

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    RUN,
    FLUSH_PUSH,
    FLUSH_DONE
  } pack_state_e;
endpackage

// File: rtl/iq_packer_fifo_if.sv
// Sample stream in, FX3 writer read port and status out.
// The master side is the surrounding logic; the slave side is iq_packer_fifo.
interface iq_packer_fifo_if #(
  parameter int DEPTH_LOG2 = 9,
  parameter int SAMPLE_W   = 16
);
  import usb_stream_pkg::*;

  logic                en;
  logic                s_valid;
  logic [SAMPLE_W-1:0] s_i;
  logic [SAMPLE_W-1:0] s_q;
  logic                rd_fifo;
  logic                ovf_clr;
  word_t               DATA_o;
  logic                fifo_empty;
  logic                fifo_full;
  logic [DEPTH_LOG2:0] fifo_level;
  logic                change;
  logic                overflow;
  logic [15:0]         ovf_cnt;

  modport master (
    output en, s_valid, s_i, s_q, rd_fifo, ovf_clr,
    input  DATA_o, fifo_empty, fifo_full, fifo_level, change, overflow, ovf_cnt
  );

  modport slave (
    input  en, s_valid, s_i, s_q, rd_fifo, ovf_clr,
    output DATA_o, fifo_empty, fifo_full, fifo_level, change, overflow, ovf_cnt
  );
endinterface

// File: rtl/sync_fifo_128.sv
// Single-clock RAM FIFO of 128-bit words with registered read data, flags and level,
// plus sticky overflow and a saturating dropped-word counter.
module sync_fifo_128
  import usb_stream_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                FX3_ifclk,
  input  logic                rst,
  input  logic                wr_en,
  input  word_t               wr_data,
  input  logic                rd_en,
  input  logic                ovf_clr,
  output word_t               rd_data,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  output logic [15:0]         ovf_cnt
);
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  word_t                 mem [1 << DEPTH_LOG2];
  word_t                 rd_data_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  empty_q, empty_d, full_q, full_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           ovf_cnt_q, ovf_cnt_d;
  logic                  rd_ok, wr_ok, drop;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    rd_ok      = rd_en & ~empty_q;
    // A read in the same cycle frees the slot, so a write on a full FIFO still lands.
    wr_ok      = wr_en & (~full_q | rd_ok);
    drop       = wr_en & full_q & ~rd_ok;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    ovf_cnt_d  = ovf_cnt_q;

    if (wr_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    if (wr_ok && !rd_ok) level_d = level_q + (DEPTH_LOG2+1)'(1);
    else if (rd_ok && !wr_ok) level_d = level_q - (DEPTH_LOG2+1)'(1);

    empty_d = (level_d == '0);
    full_d  = (level_d == FULL_LEVEL);

    if (ovf_clr) begin
      overflow_d = drop;
      ovf_cnt_d  = {15'd0, drop};
    end else if (drop) begin
      overflow_d = 1'b1;
      if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge FX3_ifclk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  // NOTE: the storage array is not reset; empty/level gate every read, so stale words never escape.
  always_ff @(posedge FX3_ifclk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  // When full, read and write hit the same address; the read returns the old word.
  always_ff @(posedge FX3_ifclk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else if (rd_ok) rd_data_q <= mem[rd_ptr_q];
  end

  assign rd_data  = rd_data_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign ovf_cnt  = ovf_cnt_q;
endmodule

// File: rtl/iq_packer_fifo.sv
// Packs {Q,I} sample pairs four to a 128-bit word and queues them for the FX3 writer;
// a falling enable flushes the partial word and then pulses 'change' for a packet end.
module iq_packer_fifo
  import usb_stream_pkg::*;
#(
  parameter int DEPTH_LOG2 = $clog2(FX3_BUF_BYTES / (WORD_W / 8)),
  parameter int SAMPLE_W   = LANE_W / 2
) (
  input logic            FX3_ifclk,
  input logic            rst,
  iq_packer_fifo_if.slave bus
);
  pack_state_e           state_q, state_d;
  logic [LANE_CNT_W-1:0] lane_cnt_q, lane_cnt_d;
  word_t                 word_q, word_d;
  logic                  en_dly_q, en_dly_d;
  logic                  fall;
  logic                  push;
  word_t                 push_word;
  lane_t                 lane;

  assign lane = {bus.s_q, bus.s_i};

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    word_d     = word_q;
    en_dly_d   = bus.en;
    push       = 1'b0;
    push_word  = word_q;
    fall       = en_dly_q & ~bus.en;

    if (state_q == FLUSH_PUSH) begin
      // Unwritten lanes are still zero because the assembly word is cleared on every push.
      push       = 1'b1;
      word_d     = '0;
      lane_cnt_d = '0;
      state_d    = FLUSH_DONE;
    end else begin
      state_d = RUN;
      if (bus.s_valid && bus.en) begin
        for (int k = 0; k < LANES; k++) begin
          if (lane_cnt_q == LANE_CNT_W'(k)) push_word[k*LANE_W +: LANE_W] = lane;
        end
        if (lane_cnt_q == LANE_CNT_W'(LANES - 1)) begin
          push   = 1'b1;
          word_d = '0;
        end else begin
          word_d = push_word;
        end
        lane_cnt_d = lane_cnt_q + LANE_CNT_W'(1);
      end
      if (fall) state_d = (lane_cnt_q != '0) ? FLUSH_PUSH : FLUSH_DONE;
    end
  end

  always_ff @(posedge FX3_ifclk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      lane_cnt_q <= '0;
      word_q     <= '0;
      en_dly_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      word_q     <= word_d;
      en_dly_q   <= en_dly_d;
    end
  end

  assign bus.change = (state_q == FLUSH_DONE);

  sync_fifo_128 #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .FX3_ifclk(FX3_ifclk),
    .rst      (rst),
    .wr_en    (push),
    .wr_data  (push_word),
    .rd_en    (bus.rd_fifo),
    .ovf_clr  (bus.ovf_clr),
    .rd_data  (bus.DATA_o),
    .empty    (bus.fifo_empty),
    .full     (bus.fifo_full),
    .level    (bus.fifo_level),
    .overflow (bus.overflow),
    .ovf_cnt  (bus.ovf_cnt)
  );
endmodule

// File: tb/tb_iq_packer_fifo.sv
// Bench for iq_packer_fifo: directed vector table, hand sequences for full/overflow/reset,
// and random traffic, all checked every cycle against a queue-based reference model.
module tb_iq_packer_fifo;
  import usb_stream_pkg::*;

  localparam int DL2   = 9;
  localparam int DEPTH = 1 << DL2;

  logic FX3_ifclk = 1'b0;
  logic rst       = 1'b1;

  always #5 FX3_ifclk = ~FX3_ifclk;

  iq_packer_fifo_if #(.DEPTH_LOG2(DL2), .SAMPLE_W(16)) bus ();

  iq_packer_fifo #(.DEPTH_LOG2(DL2), .SAMPLE_W(16)) dut (
    .FX3_ifclk(FX3_ifclk),
    .rst      (rst),
    .bus      (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0]  m_lanes[$];
  logic [127:0] m_fifo[$];
  logic [127:0] m_data;
  bit           m_flush_pend, m_en_prev, m_change, m_ovf;
  logic [15:0]  m_cnt;

  typedef struct {
    logic         en;
    logic         sv;
    logic [15:0]  si;
    logic [15:0]  sq;
    logic         rd;
    int           exp_level;
    logic         exp_change;
    logic [127:0] exp_data;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lanes.delete();
    m_fifo.delete();
    m_data       = '0;
    m_flush_pend = 0;
    m_en_prev    = 0;
    m_change     = 0;
    m_ovf        = 0;
    m_cnt        = '0;
  endtask

  // Next-state of the model for one clock edge with the given inputs.
  task automatic model_step(input logic en, input logic sv, input logic [15:0] si,
                            input logic [15:0] sq, input logic rd, input logic clr);
    bit           do_push = 0;
    bit           chg     = 0;
    bit           drop    = 0;
    logic [127:0] w       = '0;
    if (m_flush_pend) begin
      foreach (m_lanes[k]) w[32*k +: 32] = m_lanes[k];
      m_lanes.delete();
      do_push      = 1;
      chg          = 1;
      m_flush_pend = 0;
    end else begin
      if (en && sv) begin
        m_lanes.push_back({sq, si});
        if (m_lanes.size() == 4) begin
          foreach (m_lanes[k]) w[32*k +: 32] = m_lanes[k];
          m_lanes.delete();
          do_push = 1;
        end
      end
      if (m_en_prev && !en) begin
        if (m_lanes.size() != 0) m_flush_pend = 1;
        else chg = 1;
      end
    end
    m_en_prev = en;
    if (rd && m_fifo.size() > 0) m_data = m_fifo.pop_front();
    if (do_push) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
      else drop = 1;
    end
    if (clr) begin
      m_ovf = drop;
      m_cnt = drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      m_ovf = 1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    m_change = chg;
  endtask

  task automatic compare_model();
    check("data_o", bus.DATA_o, m_data);
    check("fifo_empty", 128'(bus.fifo_empty), 128'(m_fifo.size() == 0));
    check("fifo_full", 128'(bus.fifo_full), 128'(m_fifo.size() == DEPTH));
    check("fifo_level", 128'(bus.fifo_level), 128'(m_fifo.size()));
    check("change", 128'(bus.change), 128'(m_change));
    check("overflow", 128'(bus.overflow), 128'(m_ovf));
    check("ovf_cnt", 128'(bus.ovf_cnt), 128'(m_cnt));
  endtask

  // Called at a falling edge: drive inputs, advance model, compare after the rising edge.
  task automatic cycle(input logic en, input logic sv, input logic [15:0] si,
                       input logic [15:0] sq, input logic rd, input logic clr);
    bus.en      = en;
    bus.s_valid = sv;
    bus.s_i     = si;
    bus.s_q     = sq;
    bus.rd_fifo = rd;
    bus.ovf_clr = clr;
    model_step(en, sv, si, sq, rd, clr);
    @(posedge FX3_ifclk);
    @(negedge FX3_ifclk);
    compare_model();
  endtask

  function automatic logic [127:0] mk_word(input logic [15:0] base);
    logic [127:0] w;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] si;
      si = base + 16'(k);
      w[32*k +: 32] = {si ^ 16'h5A00, si};
    end
    return w;
  endfunction

  task automatic send_word(input logic [15:0] base, input int rd_at, input int clr_at);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] si;
      si = base + 16'(k);
      cycle(1'b1, 1'b1, si, si ^ 16'h5A00, k == rd_at, k == clr_at);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < DEPTH + 4 && m_fifo.size() > 0; n++) cycle(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"}, bus.DATA_o, '0);
    check({tag, "_empty"}, 128'(bus.fifo_empty), 128'(1));
    check({tag, "_full"}, 128'(bus.fifo_full), 128'(0));
    check({tag, "_level"}, 128'(bus.fifo_level), 128'(0));
    check({tag, "_change"}, 128'(bus.change), 128'(0));
    check({tag, "_overflow"}, 128'(bus.overflow), 128'(0));
    check({tag, "_ovf_cnt"}, 128'(bus.ovf_cnt), 128'(0));
  endtask

  task automatic add(input logic en, input logic sv, input logic [15:0] si, input logic [15:0] sq,
                     input logic rd, input int lvl, input logic chg, input logic [127:0] data);
    vec_t v;
    v.en = en; v.sv = sv; v.si = si; v.sq = sq; v.rd = rd;
    v.exp_level = lvl; v.exp_change = chg; v.exp_data = data;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] w0, w1, wp, wl, held;
    w0 = 128'h0103_0003_0102_0002_0101_0001_0100_0000;
    w1 = 128'h0107_0007_0106_0006_0105_0005_0104_0004;
    wp = 128'h0000_0000_0022_0012_0021_0011_0020_0010;
    wl = 128'h0043_0033_0042_0032_0041_0031_0040_0030;

    bus.en = 0; bus.s_valid = 0; bus.s_i = '0; bus.s_q = '0; bus.rd_fifo = 0; bus.ovf_clr = 0;
    model_reset();
    repeat (3) @(negedge FX3_ifclk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge FX3_ifclk);
    compare_model();

    // Eight samples -> two words, read back; 3-sample flush; flush with nothing pending;
    // reads on an empty FIFO; next word starts at lane 0.
    add(1, 0, 16'h0, 16'h0, 0, 0, 0, '0);
    for (int n = 0; n < 8; n++)
      add(1, 1, 16'(n), 16'(16'h100 + n), 0, (n < 3) ? 0 : (n < 7) ? 1 : 2, 0, '0);
    add(1, 0, 16'h0, 16'h0, 1, 1, 0, w0);
    add(1, 0, 16'h0, 16'h0, 1, 0, 0, w1);
    for (int n = 0; n < 3; n++) add(1, 1, 16'(16'h10 + n), 16'(16'h20 + n), 0, 0, 0, w1);
    add(0, 0, 16'h0, 16'h0, 0, 0, 0, w1);
    add(0, 0, 16'h0, 16'h0, 0, 1, 1, w1);
    add(0, 0, 16'h0, 16'h0, 0, 1, 0, w1);
    add(1, 0, 16'h0, 16'h0, 1, 0, 0, wp);
    add(0, 0, 16'h0, 16'h0, 0, 0, 1, wp);
    add(0, 0, 16'h0, 16'h0, 1, 0, 0, wp);
    add(0, 0, 16'h0, 16'h0, 1, 0, 0, wp);
    for (int n = 0; n < 4; n++)
      add(1, 1, 16'(16'h30 + n), 16'(16'h40 + n), 0, (n < 3) ? 0 : 1, 0, wp);
    add(1, 0, 16'h0, 16'h0, 1, 0, 0, wl);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].en, tbl[i].sv, tbl[i].si, tbl[i].sq, tbl[i].rd, 1'b0);
      check($sformatf("tbl%0d_level", i), 128'(bus.fifo_level), 128'(tbl[i].exp_level));
      check($sformatf("tbl%0d_empty", i), 128'(bus.fifo_empty), 128'(tbl[i].exp_level == 0));
      check($sformatf("tbl%0d_change", i), 128'(bus.change), 128'(tbl[i].exp_change));
      check($sformatf("tbl%0d_data", i), bus.DATA_o, tbl[i].exp_data);
      check($sformatf("tbl%0d_overflow", i), 128'(bus.overflow), 128'(0));
    end

    // Fill to 512 words, then three more pushes are dropped; then clear.
    for (int w = 0; w < DEPTH + 3; w++) send_word(16'(w * 4), -1, -1);
    check("fill_full", 128'(bus.fifo_full), 128'(1));
    check("fill_level", 128'(bus.fifo_level), 128'(DEPTH));
    check("fill_ovf_cnt", 128'(bus.ovf_cnt), 128'(3));
    check("fill_overflow", 128'(bus.overflow), 128'(1));
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    check("clr_ovf_cnt", 128'(bus.ovf_cnt), 128'(0));
    check("clr_overflow", 128'(bus.overflow), 128'(0));

    // Full FIFO: read and push in the same cycle -> accepted, level unchanged.
    send_word(16'h4000, 3, -1);
    check("fullrw_level", 128'(bus.fifo_level), 128'(DEPTH));
    check("fullrw_overflow", 128'(bus.overflow), 128'(0));
    check("fullrw_data", bus.DATA_o, mk_word(16'h0000));
    // Clear coinciding with a drop.
    send_word(16'h4100, -1, 3);
    check("clrdrop_overflow", 128'(bus.overflow), 128'(1));
    check("clrdrop_ovf_cnt", 128'(bus.ovf_cnt), 128'(1));
    drain();

    // Reads on an empty FIFO are ignored.
    held = mk_word(16'h4000);
    repeat (3) cycle(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    check("empty_rd_data", bus.DATA_o, held);
    check("empty_rd_level", 128'(bus.fifo_level), 128'(0));
    check("empty_rd_empty", 128'(bus.fifo_empty), 128'(1));

    // 600 words with interleaved reads: pointers wrap, order checked by the model.
    for (int w = 0; w < 600; w++) send_word(16'(16'h8000 + w * 4), int'($urandom_range(0, 4)), -1);
    drain();
    check("wrap_level", 128'(bus.fifo_level), 128'(0));

    // Random traffic including enable drops, flushes and clears.
    for (int c = 0; c < 3000; c++) begin
      logic en_r, sv_r, rd_r, clr_r;
      logic [15:0] si_r, sq_r;
      en_r  = ($urandom_range(0, 15) != 0);
      sv_r  = ($urandom_range(0, 3) != 0);
      rd_r  = ($urandom_range(0, 3) == 0);
      clr_r = ($urandom_range(0, 63) == 0);
      si_r  = 16'($urandom);
      sq_r  = 16'($urandom);
      cycle(en_r, sv_r, si_r, sq_r, rd_r, clr_r);
    end

    // Reset mid-word with a stored word and two lanes pending.
    send_word(16'h2000, -1, -1);
    cycle(1'b1, 1'b1, 16'h2222, 16'h3333, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h2223, 16'h3334, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    model_reset();
    bus.en = 0; bus.s_valid = 0; bus.rd_fifo = 0; bus.ovf_clr = 0;
    @(negedge FX3_ifclk);
    rst = 1'b0;
    @(negedge FX3_ifclk);
    compare_model();
    send_word(16'h0900, -1, -1);
    cycle(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    check("postrst_data", bus.DATA_o, mk_word(16'h0900));
    check("postrst_level", 128'(bus.fifo_level), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
